// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   F3_*          funct3 encodings of the M-extension ops
//   mdu_state_t   control FSM states
//   XLEN_DEFAULT  default operand width
package riscv_m_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i / quo_i  partial remainder and dividend/quotient shift register
//   div_i          divisor magnitude
//   rem_o / quo_o  updated remainder and quotient (new quotient bit shifted in at LSB)
module mdu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // Bring the next dividend bit into the remainder, then trial-subtract.
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    // Top bit of diff is the borrow: set means the trial subtract went negative.
    if (diff[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Latches operands on start, runs XLEN shift-add or
// restoring shift-subtract steps on magnitudes, sign-corrects and issues a one-cycle write.
//   clk, rst                 clock, async active-high reset
//   start, funct3            issue request and op select (sampled only in IDLE)
//   rs1_val, rs2_val, rd_addr  operands and destination
//   stall, busy              core hold / unit occupied
//   wb_we, wb_addr, wb_data  register-file write port
module mul_div_unit
  import riscv_m_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            stall,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [XLEN-1:0] SignMin = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic              neg_q_q, neg_q_d;  // negate product / quotient
  logic              neg_r_q, neg_r_d;  // negate remainder
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  // Issue-side decode on live inputs
  logic            signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = signed_a & rs1_val[XLEN-1];
    b_neg    = signed_b & rs2_val[XLEN-1];
    abs_a    = a_neg ? -rs1_val : rs1_val;
    abs_b    = b_neg ? -rs2_val : rs2_val;
    div_zero = funct3[2] && (rs2_val == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_val == SignMin) && (rs2_val == '1);
    if (div_zero) begin
      special_res = funct3[1] ? rs1_val : '1;
    end else begin
      special_res = funct3[1] ? '0 : SignMin;
    end
  end

  // Datapath step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, step_next, prod_fix;
  logic [XLEN-1:0]   div_rem, div_quo, calc_res;

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i(acc_q[2*XLEN-1:XLEN]),
    .quo_i(acc_q[XLEN-1:0]),
    .div_i(b_q),
    .rem_o(div_rem),
    .quo_o(div_quo)
  );

  always_comb begin
    // Shift-add: add multiplicand into the high half when the multiplier LSB is set.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    step_next = f3_q[2] ? {div_rem, div_quo} : mul_next;
    prod_fix  = neg_q_q ? -step_next : step_next;
    case (f3_q)
      F3_MUL:                       calc_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              calc_res = neg_q_q ? -step_next[XLEN-1:0]
                                                       : step_next[XLEN-1:0];
      default:                      calc_res = neg_r_q ? -step_next[2*XLEN-1:XLEN]
                                                       : step_next[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    stall     = 1'b0;
    wb_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          count_d = '0;
          f3_d    = funct3;
          rd_d    = rd_addr;
          b_d     = abs_b;
          acc_d   = {{XLEN{1'b0}}, abs_a};
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          if (div_zero || div_ovf) begin
            state_d   = DONE;
            wb_addr_d = rd_addr;
            wb_data_d = special_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall   = 1'b1;
        acc_d   = step_next;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d   = DONE;
          wb_addr_d = rd_q;
          wb_data_d = calc_res;
        end
      end
      DONE: begin
        wb_we   = (rd_q != 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, every op class, special cases, rd=0 and
// start-while-busy behaviour, with hand-computed expected results and latencies.
module tb_mul_div_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        stall, busy, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .XLEN(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .stall   (stall),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after the start edge, watch 40 cycles.
  // exp_lat = 0 means no write is expected (rd=0); stall then covers a full 33 cycles.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input bit poke);
    int          first_we = 0;
    int          n_we     = 0;
    int          n_stall  = 0;
    logic [31:0] got_data = '0;
    logic [4:0]  got_addr = '0;
    @(negedge clk);
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_addr = rd;
    #1;
    if (stall) n_stall++;
    @(negedge clk);
    start   = 1'b0;
    funct3  = F3_DIVU;
    rs1_val = 32'h1234_5678;
    rs2_val = 32'h0000_0001;
    rd_addr = 5'd31;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (stall) n_stall++;
      if (wb_we) begin
        n_we++;
        if (first_we == 0) begin
          first_we = k;
          got_data = wb_data;
          got_addr = wb_addr;
        end
      end
      if (poke && k == 5) begin
        start   = 1'b1;
        funct3  = F3_MULHU;
        rs1_val = 32'hFFFF_FFFF;
        rs2_val = 32'hFFFF_FFFF;
        rd_addr = 5'd3;
      end
      if (poke && k == 6) start = 1'b0;
      @(negedge clk);
    end
    if (exp_lat != 0) begin
      check_eq({tag, "_lat"}, 64'(first_we), 64'(exp_lat));
      check_eq({tag, "_data"}, {32'h0, got_data}, {32'h0, exp_data});
      check_eq({tag, "_addr"}, {59'h0, got_addr}, {59'h0, rd});
      check_eq({tag, "_nwe"}, 64'(n_we), 64'd1);
      check_eq({tag, "_stall"}, 64'(n_stall), 64'(exp_lat));
    end else begin
      check_eq({tag, "_nwe"}, 64'(n_we), 64'd0);
      check_eq({tag, "_stall"}, 64'(n_stall), 64'd33);
    end
    check_eq({tag, "_idle"}, {63'h0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we = 0;
    rst     = 1'b1;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_addr = '0;
    #1;
    check_eq("rst_stall", {63'h0, stall}, 64'd0);
    check_eq("rst_busy", {63'h0, busy}, 64'd0);
    check_eq("rst_we", {63'h0, wb_we}, 64'd0);
    check_eq("rst_addr", {59'h0, wb_addr}, 64'd0);
    check_eq("rst_data", {32'h0, wb_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mul", F3_MUL, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 33, 1'b0);

    // Reset in the middle of a divide: everything drops immediately, no write follows.
    @(negedge clk);
    start   = 1'b1;
    funct3  = F3_DIV;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    rd_addr = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_busy_pre", {63'h0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_stall", {63'h0, stall}, 64'd0);
    check_eq("abort_busy", {63'h0, busy}, 64'd0);
    check_eq("abort_we", {63'h0, wb_we}, 64'd0);
    check_eq("abort_data", {32'h0, wb_data}, 64'd0);
    check_eq("abort_addr", {59'h0, wb_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_we) n_we++;
    end
    check_eq("abort_nwe", 64'(n_we), 64'd0);

    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 1'b0);
    run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div", F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd4, 32'hFFFF_FFFA, 33, 1'b0);
    run_op("rem", F3_REM, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("divu", F3_DIVU, 32'd20, 32'd3, 5'd7, 32'd6, 33, 1'b0);
    run_op("remu", F3_REMU, 32'd20, 32'd3, 5'd8, 32'd2, 33, 1'b0);
    run_op("div0", F3_DIV, 32'd9, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem0", F3_REM, 32'd9, 32'd0, 5'd11, 32'd9, 1, 1'b0);
    run_op("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 1'b0);
    run_op("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, 1'b0);
    run_op("rd0", F3_MUL, 32'd3, 32'd3, 5'd0, 32'd9, 0, 1'b0);
    run_op("poke", F3_MUL, 32'd7, 32'd6, 5'd7, 32'h0000_002A, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
